// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm: sequences fetch/decode/execute/writeback control lines for the 8-bit multicycle datapath
module multicycle_control_fsm #(
    parameter bit HALT_ON_ILLEGAL = 1'b0
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       run,
    input  logic [7:0] OpCode,
    input  logic       N,
    input  logic       Z,
    output logic       PCwrite,
    output logic       AddrSel,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRload,
    output logic       MDRload,
    output logic       RASel,
    output logic       RFWrite,
    output logic       RegIn,
    output logic       ABLD,
    output logic       ALU_A,
    output logic       FlagWrite,
    output logic       ALUoutLD,
    output logic [2:0] ALU_B,
    output logic [2:0] ALUop,
    output logic       halted,
    output logic [3:0] state
);
    typedef enum logic [3:0] {
        FETCH1 = 4'd0, FETCH2 = 4'd1, DECODE = 4'd2, LD1 = 4'd3, LD2 = 4'd4,
        LD3 = 4'd5, ST1 = 4'd6, EX = 4'd7, WB = 4'd8, BR = 4'd9, HALT = 4'd15
    } state_t;

    state_t st;
    logic [3:0] op;
    logic is_ld, is_st, is_alu, is_ori, is_sh, is_br, is_stop, taken;
    logic unused_op;

    assign op        = OpCode[3:0];
    assign unused_op = ^{OpCode[7:6], OpCode[4]};
    assign is_ld     = op == 4'b0000;
    assign is_st     = op == 4'b0010;
    assign is_alu    = op == 4'b0100 || op == 4'b0110 || op == 4'b1000;
    assign is_ori    = op[2:0] == 3'b111;
    assign is_sh     = op[2:0] == 3'b011;
    assign is_br     = op == 4'b0101 || op == 4'b1001 || op == 4'b1101;
    assign is_stop   = op == 4'b0001;
    assign taken     = op == 4'b0101 ? Z : op == 4'b1001 ? !Z : !N;

    always_ff @(posedge CLOCK_50) begin
        if (reset)
            st <= FETCH1;
        else
            case (st)
                FETCH1:           st <= run ? FETCH2 : FETCH1;
                FETCH2:           st <= DECODE;
                DECODE:           st <= is_ld ? LD1 : is_st ? ST1 : (is_alu || is_ori || is_sh) ? EX :
                                        is_br ? BR : is_stop ? HALT : HALT_ON_ILLEGAL ? HALT : FETCH1;
                LD1:              st <= LD2;
                LD2:              st <= LD3;
                EX:               st <= WB;
                HALT:             st <= HALT;
                default:          st <= FETCH1;
            endcase
    end

    // Decoded straight from the state register: the IR is only valid from DECODE on,
    // so DECODE's RASel cannot be precomputed a cycle early.
    assign state     = st;
    assign PCwrite   = st == FETCH2 || (st == BR && taken);
    assign AddrSel   = st == FETCH1;
    assign MemRead   = st == FETCH1 || st == LD1;
    assign MemWrite  = st == ST1;
    assign IRload    = st == FETCH2;
    assign MDRload   = st == LD2;
    assign RASel     = (st == DECODE || st == WB) && is_ori;
    assign RFWrite   = st == LD3 || st == WB;
    assign RegIn     = st == LD3;
    assign ABLD      = st == DECODE;
    assign ALU_A     = st == EX;
    assign FlagWrite = st == EX;
    assign ALUoutLD  = st == EX;
    assign halted    = st == HALT;
    assign ALU_B     = st == FETCH2 ? 3'b001 : st == BR ? 3'b010 :
                       st != EX ? 3'b000 : is_ori ? 3'b011 : is_sh ? 3'b100 : 3'b000;
    assign ALUop     = st != EX ? 3'b000 : is_ori ? 3'b010 : is_sh ? {2'b10, OpCode[5]} :
                       op == 4'b0110 ? 3'b001 : op == 4'b1000 ? 3'b011 : 3'b000;
endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb_multicycle_control_fsm: scoreboard bench walking every instruction class through the control FSM
module tb_multicycle_control_fsm;
    logic clk = 1'b0, reset = 1'b1, run = 1'b0, N = 1'b0, Z = 1'b0;
    logic [7:0] OpCode = 8'h00;
    logic PCwrite, AddrSel, MemRead, MemWrite, IRload, MDRload, RASel, RFWrite, RegIn;
    logic ABLD, ALU_A, FlagWrite, ALUoutLD, halted;
    logic [2:0] ALU_B, ALUop;
    logic [3:0] state;
    logic h_PCwrite, h_AddrSel, h_MemRead, h_MemWrite, h_IRload, h_MDRload, h_RASel, h_RFWrite, h_RegIn;
    logic h_ABLD, h_ALU_A, h_FlagWrite, h_ALUoutLD, h_halted;
    logic [2:0] h_ALU_B, h_ALUop;
    logic [3:0] h_state;
    logic [23:0] act;
    logic [23:0] sb[$];
    int checks = 0, errors = 0;

    multicycle_control_fsm #(.HALT_ON_ILLEGAL(1'b0)) dut (
        .CLOCK_50(clk), .reset(reset), .run(run), .OpCode(OpCode), .N(N), .Z(Z),
        .PCwrite(PCwrite), .AddrSel(AddrSel), .MemRead(MemRead), .MemWrite(MemWrite),
        .IRload(IRload), .MDRload(MDRload), .RASel(RASel), .RFWrite(RFWrite), .RegIn(RegIn),
        .ABLD(ABLD), .ALU_A(ALU_A), .FlagWrite(FlagWrite), .ALUoutLD(ALUoutLD),
        .ALU_B(ALU_B), .ALUop(ALUop), .halted(halted), .state(state)
    );

    multicycle_control_fsm #(.HALT_ON_ILLEGAL(1'b1)) dut_h (
        .CLOCK_50(clk), .reset(reset), .run(run), .OpCode(OpCode), .N(N), .Z(Z),
        .PCwrite(h_PCwrite), .AddrSel(h_AddrSel), .MemRead(h_MemRead), .MemWrite(h_MemWrite),
        .IRload(h_IRload), .MDRload(h_MDRload), .RASel(h_RASel), .RFWrite(h_RFWrite), .RegIn(h_RegIn),
        .ABLD(h_ABLD), .ALU_A(h_ALU_A), .FlagWrite(h_FlagWrite), .ALUoutLD(h_ALUoutLD),
        .ALU_B(h_ALU_B), .ALUop(h_ALUop), .halted(h_halted), .state(h_state)
    );

    always #5 clk = ~clk;

    assign act = {PCwrite, AddrSel, MemRead, MemWrite, IRload, MDRload, RASel, RFWrite, RegIn,
                  ABLD, ALU_A, FlagWrite, ALUoutLD, ALU_B, ALUop, halted, state};

    // Expected control word for a state, straight from the state action table.
    function automatic logic [23:0] model(input logic [3:0] s, input logic [7:0] op, input logic n, input logic z);
        logic pcw = 0, asel = 0, mr = 0, mw = 0, irl = 0, mdrl = 0, ras = 0, rfw = 0, rin = 0;
        logic abld = 0, alua = 0, fw = 0, aold = 0, hlt = 0;
        logic [2:0] alub = 3'b000, aluop = 3'b000;
        logic ori, sh;
        ori = op[2:0] == 3'b111;
        sh  = op[2:0] == 3'b011;
        case (s)
            4'd0: begin asel = 1; mr = 1; end
            4'd1: begin irl = 1; pcw = 1; alub = 3'b001; end
            4'd2: begin abld = 1; ras = ori; end
            4'd3: mr = 1;
            4'd4: mdrl = 1;
            4'd5: begin rin = 1; rfw = 1; end
            4'd6: mw = 1;
            4'd7: begin
                alua = 1; aold = 1; fw = 1;
                if (ori) begin alub = 3'b011; aluop = 3'b010; end
                else if (sh) begin alub = 3'b100; aluop = op[5] ? 3'b101 : 3'b100; end
                else if (op[3:0] == 4'b0110) aluop = 3'b001;
                else if (op[3:0] == 4'b1000) aluop = 3'b011;
            end
            4'd8: begin rfw = 1; ras = ori; end
            4'd9: begin
                alub = 3'b010;
                case (op[3:0])
                    4'b0101: pcw = z;
                    4'b1001: pcw = !z;
                    default: pcw = !n;
                endcase
            end
            4'd15: hlt = 1;
            default: ;
        endcase
        return {pcw, asel, mr, mw, irl, mdrl, ras, rfw, rin, abld, alua, fw, aold, alub, aluop, hlt, s};
    endfunction

    // Starts and ends at a negedge with the DUT in FETCH1; seq holds one state nibble per cycle, MSB first.
    task automatic do_instr(input string name, input logic [7:0] op, input logic n, input logic z,
                            input int len, input logic [31:0] seq, input bit drop);
        logic [23:0] e;
        OpCode = op; N = n; Z = z; run = 1'b1;
        for (int i = 0; i < len; i++) sb.push_back(model(seq[(len-1-i)*4 +: 4], op, n, z));
        for (int i = 0; i < len; i++) begin
            if (i > 0) @(negedge clk);
            if (drop && i == 1) run = 1'b0;
            e = sb.pop_front();
            checks++;
            if (act !== e) begin
                errors++;
                $display("FAIL %s step %0d: got %h expected %h", name, i, act, e);
            end
            checks++;
            if ((MemRead && MemWrite) || (RFWrite && ABLD)) begin
                errors++;
                $display("FAIL %s exclusivity step %0d: got MemRead=%b MemWrite=%b RFWrite=%b ABLD=%b", name, i, MemRead, MemWrite, RFWrite, ABLD);
            end
        end
    endtask

    task automatic test_reset;
        logic [23:0] e;
        reset = 1'b1; run = 1'b1;
        @(negedge clk);
        @(negedge clk);
        e = model(4'd0, 8'h00, 1'b0, 1'b0);
        checks++;
        if (act !== e) begin errors++; $display("FAIL reset_held: got %h expected %h", act, e); end
        reset = 1'b0;
        checks++;
        if (h_state !== 4'd0 || h_halted !== 1'b0) begin
            errors++; $display("FAIL reset_h: got state %0d halted %b expected 0 0", h_state, h_halted);
        end
    endtask

    task automatic test_alu;
        do_instr("add", 8'h14, 1'b0, 1'b0, 6, 32'h012780, 1'b0);
        do_instr("sub", 8'h16, 1'b1, 1'b0, 6, 32'h012780, 1'b0);
        do_instr("nand", 8'h18, 1'b0, 1'b1, 6, 32'h012780, 1'b0);
        do_instr("ori", 8'h2F, 1'b0, 1'b0, 6, 32'h012780, 1'b0);
        do_instr("shr", 8'h2B, 1'b0, 1'b0, 6, 32'h012780, 1'b0);
        do_instr("shl", 8'h0B, 1'b0, 1'b0, 6, 32'h012780, 1'b0);
    endtask

    task automatic test_mem;
        do_instr("load", 8'h10, 1'b0, 1'b0, 7, 32'h0123450, 1'b0);
        do_instr("store", 8'h02, 1'b0, 1'b0, 5, 32'h01260, 1'b0);
    endtask

    task automatic test_branch;
        do_instr("bz_taken", 8'h35, 1'b0, 1'b1, 5, 32'h01290, 1'b0);
        do_instr("bz_not", 8'h35, 1'b1, 1'b0, 5, 32'h01290, 1'b0);
        do_instr("bnz_taken", 8'h39, 1'b1, 1'b0, 5, 32'h01290, 1'b0);
        do_instr("bnz_not", 8'h39, 1'b0, 1'b1, 5, 32'h01290, 1'b0);
        do_instr("bpz_taken", 8'h3D, 1'b0, 1'b1, 5, 32'h01290, 1'b0);
        do_instr("bpz_not", 8'h3D, 1'b1, 1'b0, 5, 32'h01290, 1'b0);
    endtask

    task automatic test_run;
        logic [23:0] e;
        run = 1'b0;
        for (int i = 0; i < 10; i++) sb.push_back(model(4'd0, OpCode, N, Z));
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (act !== e) begin errors++; $display("FAIL run_hold cycle %0d: got %h expected %h", i, act, e); end
        end
        do_instr("run_drop_load", 8'h10, 1'b0, 1'b0, 8, 32'h01234500, 1'b1);
    endtask

    task automatic test_illegal;
        do_instr("illegal_nop", 8'h0C, 1'b0, 1'b0, 4, 32'h0120, 1'b0);
        checks++;
        if (h_state !== 4'd15 || h_halted !== 1'b1) begin
            errors++; $display("FAIL illegal_halt: got state %0d halted %b expected 15 1", h_state, h_halted);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (h_state !== 4'd0 || state !== 4'd0) begin
            errors++; $display("FAIL reset_from_halt: got %0d/%0d expected 0/0", state, h_state);
        end
    endtask

    task automatic test_reset_mid;
        logic [23:0] e;
        do_instr("load_to_ld2", 8'h10, 1'b0, 1'b0, 5, 32'h01234, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        e = model(4'd0, 8'h10, 1'b0, 1'b0);
        checks++;
        if (act !== e) begin errors++; $display("FAIL reset_ld2: got %h expected %h", act, e); end
        reset = 1'b0;
    endtask

    task automatic test_halt;
        logic [23:0] e;
        do_instr("stop", 8'h01, 1'b0, 1'b0, 8, 32'h012FFFFF, 1'b1);
        for (int i = 0; i < 4; i++) begin
            run = i[0];
            @(negedge clk);
            e = model(4'd15, 8'h01, 1'b0, 1'b0);
            checks++;
            if (act !== e) begin errors++; $display("FAIL halt_hold cycle %0d: got %h expected %h", i, act, e); end
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        e = model(4'd0, 8'h01, 1'b0, 1'b0);
        checks++;
        if (act !== e) begin errors++; $display("FAIL halt_reset: got %h expected %h", act, e); end
    endtask

    initial begin
        test_reset;
        test_alu;
        test_mem;
        test_branch;
        test_run;
        test_illegal;
        test_reset_mid;
        test_halt;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
